// File: rtl/reg_access_ctrl_if.sv
// Host request/response channel between the bus bridge and reg_access_ctrl.
// master = host side, slave = controller side.
interface reg_access_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Serialised host access to an update-strobed register bank: IDLE->EXEC->RESP, rsp_valid two cycles after the accept cycle, stalls in RESP while rsp_ready is low.
// Optional macro REG_ACCESS_ERR_EN flags out-of-range addresses on rsp_err; otherwise rsp_err is tied 0.
module reg_access_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_access_ctrl_if.slave       bus,
  output logic [NREGS-1:0]       reg_update,
  output logic [WIDTH-1:0]       reg_new_value,
  input  logic [NREGS*WIDTH-1:0] reg_curr_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Write data lives in reg_new_value, so only the command and address are captured.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
  } req_t;

  state_t           state_q;
  state_t           state_d;
  req_t             cap_q;
  logic [NREGS-1:0] wr_onehot;
  logic [WIDTH-1:0] rd_sel;
  logic             hit;
  logic [WIDTH-1:0] rsp_rdata_q;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decodes match only in-range indices, so out-of-range accesses fall out as no strobe / zero data.
  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.req_addr == AW'(i)) wr_onehot[i] = bus.req_wr;
    end
  end

  always_comb begin
    rd_sel = '0;
    hit    = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (cap_q.addr == AW'(i)) begin
        rd_sel = reg_curr_value[i*WIDTH +: WIDTH];
        hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cap_q         <= '0;
      reg_update    <= '0;
      reg_new_value <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      reg_update <= '0;
      if (state_q == IDLE && bus.req_valid) begin
        cap_q      <= '{wr: bus.req_wr, addr: bus.req_addr};
        reg_update <= wr_onehot;
        if (bus.req_wr) reg_new_value <= bus.req_wdata;
      end
      if (state_q == EXEC) rsp_rdata_q <= cap_q.wr ? '0 : rd_sel;
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef REG_ACCESS_ERR_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_err_q <= ~hit;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl with a 6-entry register bank looped back onto reg_curr_value.
module tb_reg_access_ctrl;
  localparam int WIDTH = 4;
  localparam int NREGS = 6;
  localparam int AW    = 3;
`ifdef REG_ACCESS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_access_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  logic [NREGS-1:0]       reg_update;
  logic [WIDTH-1:0]       reg_new_value;
  logic [NREGS*WIDTH-1:0] reg_curr_value;

  reg_access_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .reg_update     (reg_update),
    .reg_new_value  (reg_new_value),
    .reg_curr_value (reg_curr_value)
  );

  // Register bank: loads new_value when strobed, no reset.
  logic [WIDTH-1:0] bank [NREGS] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) if (reg_update[i]) bank[i] <= reg_new_value;
  end
  always_comb begin
    reg_curr_value = '0;
    for (int i = 0; i < NREGS; i++) reg_curr_value[i*WIDTH +: WIDTH] = bank[i];
  end

  int               upd_total = 0;
  int               upd_multi = 0;
  logic [NREGS-1:0] upd_last  = '0;
  logic [WIDTH-1:0] nv_last   = '0;
  always @(negedge clk) begin
    if (reg_update != '0) begin
      upd_total <= upd_total + 1;
      upd_last  <= reg_update;
      nv_last   <= reg_new_value;
      if ($countones(reg_update) > 1) upd_multi <= upd_multi + 1;
    end
  end

  logic [WIDTH-1:0] exp_regs [NREGS] = '{default: '0};
  int tests_run = 0;
  int tests_failed = 0;

  task automatic access(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input int stall, output int lat, output logic [WIDTH-1:0] rd,
                        output logic er, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) ok = 1'b0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk); lat = 1;
    while (!bus.rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) ok = 1'b0;
    rd = bus.rsp_rdata; er = bus.rsp_err;
    repeat (stall) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2 rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== '0) begin tests_failed++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    tests_run++; if (bus.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err got %0b want 0", bus.rsp_err); end
    tests_run++; if (reg_update !== '0) begin tests_failed++; $display("FAIL reset_reg_update got %b want 0", reg_update); end
    tests_run++; if (reg_new_value !== '0) begin tests_failed++; $display("FAIL reset_new_value got %h want 0", reg_new_value); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_req_ready got %0b want 1", bus.req_ready); end
  endtask

  task automatic test_write();
    int u0, lat; logic [WIDTH-1:0] rd; logic er; bit ok;
    u0 = upd_total;
    access(1'b1, 3'd2, 4'hA, 0, lat, rd, er, ok);
    exp_regs[2] = 4'hA;
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL write_timeout got %0b want 1", ok); end
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL write_latency got %0d want 2", lat); end
    tests_run++; if (rd !== 4'h0) begin tests_failed++; $display("FAIL write_rdata got %h want 0", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL write_err got %0b want 0", er); end
    tests_run++; if (upd_total - u0 !== 1) begin tests_failed++; $display("FAIL write_strobe_cycles got %0d want 1", upd_total - u0); end
    tests_run++; if (upd_last !== 6'b000100) begin tests_failed++; $display("FAIL write_strobe got %b want 000100", upd_last); end
    tests_run++; if (nv_last !== 4'hA) begin tests_failed++; $display("FAIL write_new_value got %h want a", nv_last); end
    tests_run++; if (bank[2] !== 4'hA) begin tests_failed++; $display("FAIL write_bank got %h want a", bank[2]); end
  endtask

  task automatic test_read();
    int u0, lat; logic [WIDTH-1:0] rd; logic er; bit ok;
    access(1'b1, 3'd5, 4'h3, 0, lat, rd, er, ok);
    exp_regs[5] = 4'h3;
    u0 = upd_total;
    access(1'b0, 3'd5, 4'hF, 1, lat, rd, er, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL read_timeout got %0b want 1", ok); end
    tests_run++; if (rd !== 4'h3) begin tests_failed++; $display("FAIL read_rdata got %h want 3", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL read_err got %0b want 0", er); end
    tests_run++; if (upd_total - u0 !== 0) begin tests_failed++; $display("FAIL read_strobe got %0d cycles want 0", upd_total - u0); end
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 3'd2; bus.req_wdata = 4'h0;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.req_addr = 3'd5;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_rsp_valid cyc %0d got %0b want 1", k, bus.rsp_valid); end
      tests_run++; if (bus.rsp_rdata !== exp_regs[2]) begin tests_failed++; $display("FAIL stall_rdata cyc %0d got %h want %h", k, bus.rsp_rdata, exp_regs[2]); end
      tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_req_ready cyc %0d got %0b want 0", k, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_next_accept got %0b want 1", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_rsp_drop got %0b want 0", bus.rsp_valid); end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_exec_ready got %0b want 0", bus.req_ready); end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_second_timeout got %0b want 1", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== exp_regs[5]) begin tests_failed++; $display("FAIL stall_second_rdata got %h want %h", bus.rsp_rdata, exp_regs[5]); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int u0, lat; logic [WIDTH-1:0] rd; logic er; bit ok;
    u0 = upd_total;
    access(1'b1, 3'd1, 4'h7, 0, lat, rd, er, ok);
    exp_regs[1] = 4'h7;
    tests_run++; if (upd_last !== 6'b000010) begin tests_failed++; $display("FAIL b2b_strobe got %b want 000010", upd_last); end
    access(1'b0, 3'd1, 4'h0, 0, lat, rd, er, ok);
    tests_run++; if (rd !== 4'h7) begin tests_failed++; $display("FAIL b2b_rdata got %h want 7", rd); end
    tests_run++; if (upd_total - u0 !== 1) begin tests_failed++; $display("FAIL b2b_strobe_cycles got %0d want 1", upd_total - u0); end
  endtask

  task automatic test_out_of_range();
    int u0, lat; logic [WIDTH-1:0] rd; logic er; bit ok;
    for (int a = 6; a < 8; a++) begin
      for (int w = 0; w < 2; w++) begin
        u0 = upd_total;
        access(w[0], AW'(a), 4'($urandom), 0, lat, rd, er, ok);
        tests_run++; if (upd_total - u0 !== 0) begin tests_failed++; $display("FAIL oob_strobe addr %0d wr %0d got %0d want 0", a, w, upd_total - u0); end
        tests_run++; if (rd !== 4'h0) begin tests_failed++; $display("FAIL oob_rdata addr %0d wr %0d got %h want 0", a, w, rd); end
        tests_run++; if (er !== ERR_EN) begin tests_failed++; $display("FAIL oob_err addr %0d wr %0d got %0b want %0b", a, w, er, ERR_EN); end
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      tests_run++; if (bank[i] !== exp_regs[i]) begin tests_failed++; $display("FAIL oob_bank reg %0d got %h want %h", i, bank[i], exp_regs[i]); end
    end
  endtask

  task automatic test_random();
    int u0, m0, lat; logic [WIDTH-1:0] rd; logic er; bit ok;
    logic wr; logic [AW-1:0] a; logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_rd; logic exp_er; int exp_upd; bit in_range;
    m0 = upd_multi;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(1, 0));
      a  = AW'($urandom_range(7, 0));
      d  = WIDTH'($urandom);
      in_range = (int'(a) < NREGS);
      exp_rd  = (!wr && in_range) ? exp_regs[a] : '0;
      exp_er  = ERR_EN && !in_range;
      exp_upd = (wr && in_range) ? 1 : 0;
      u0 = upd_total;
      access(wr, a, d, $urandom_range(3, 0), lat, rd, er, ok);
      if (wr && in_range) exp_regs[a] = d;
      tests_run++; if (ok !== 1'b1 || lat !== 2) begin tests_failed++; $display("FAIL rand_latency %0d got %0d ok %0b want 2", i, lat, ok); end
      tests_run++; if (rd !== exp_rd) begin tests_failed++; $display("FAIL rand_rdata %0d wr %0b addr %0d got %h want %h", i, wr, a, rd, exp_rd); end
      tests_run++; if (er !== exp_er) begin tests_failed++; $display("FAIL rand_err %0d addr %0d got %0b want %0b", i, a, er, exp_er); end
      tests_run++; if (upd_total - u0 !== exp_upd) begin tests_failed++; $display("FAIL rand_strobe_cycles %0d got %0d want %0d", i, upd_total - u0, exp_upd); end
      if (exp_upd == 1) begin
        tests_run++; if (upd_last !== NREGS'(1 << a) || nv_last !== d) begin tests_failed++; $display("FAIL rand_strobe %0d got %b/%h want %b/%h", i, upd_last, nv_last, NREGS'(1 << a), d); end
      end
    end
    tests_run++; if (upd_multi !== m0) begin tests_failed++; $display("FAIL rand_onehot got %0d multi-bit strobes want 0", upd_multi - m0); end
    for (int i = 0; i < NREGS; i++) begin
      tests_run++; if (bank[i] !== exp_regs[i]) begin tests_failed++; $display("FAIL rand_bank reg %0d got %h want %h", i, bank[i], exp_regs[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    int u0, n, lat; logic [WIDTH-1:0] d, rd; logic er; bit ok;
    d = ~exp_regs[3];
    u0 = upd_total;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 3'd3; bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst_n = 1'b0; bus.req_valid = 1'b0;
    #1;
    tests_run++; if (reg_update !== '0) begin tests_failed++; $display("FAIL rst_exec_update got %b want 0", reg_update); end
    tests_run++; if (reg_new_value !== '0) begin tests_failed++; $display("FAIL rst_exec_new_value got %h want 0", reg_new_value); end
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_exec_req_ready got %0b want 1", bus.req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid cyc %0d got %0b want 0", k, bus.rsp_valid); end
    end
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready got %0b want 1", bus.req_ready); end
    tests_run++; if (upd_total - u0 !== 0) begin tests_failed++; $display("FAIL rst_strobe got %0d cycles want 0", upd_total - u0); end
    tests_run++; if (bank[3] !== exp_regs[3]) begin tests_failed++; $display("FAIL rst_bank got %h want %h", bank[3], exp_regs[3]); end
    access(1'b1, 3'd3, d, 0, lat, rd, er, ok);
    exp_regs[3] = d;
    tests_run++; if (bank[3] !== d) begin tests_failed++; $display("FAIL rst_recover_bank got %h want %h", bank[3], d); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
